// File: rtl/rr_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_pkg
// Shared helpers for the round-robin registered multiplexer.
//   idx_width()  : width of a channel index (clog2, never below 1)
//   DATA_RST_BIT : reset value replicated across the output data register
// Optional feature macro used by the rr_mux files: RR_MUX_FORCE_SEL_EN
// -----------------------------------------------------------------------------
package rr_mux_pkg;

  // Reset value for every bit of the registered data path (all zeros).
  localparam logic DATA_RST_BIT = 1'b0;

  // Channel index width; a two-channel mux still needs one index bit.
  function automatic int idx_width(input int n);
    int w;
    w = (n <= 2) ? 1 : $clog2(n);
    return w;
  endfunction

endpackage : rr_mux_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant generator for rr_mux. The search starts at the pointer and
// wraps modulo NUM_CH; after an accepted grant the pointer moves to the channel
// just after the winner.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   force_en, force_sel : (RR_MUX_FORCE_SEL_EN only) restrict grant to one channel
//   req                 : per-channel request (in_valid)
//   accept              : output slot can take a beat this cycle
//   gnt                 : one-hot grant (or zero)
//   gnt_idx             : encoded index of the granted channel
//   gnt_any             : some channel is granted
// Optional feature macro: RR_MUX_FORCE_SEL_EN
// -----------------------------------------------------------------------------
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
`ifdef RR_MUX_FORCE_SEL_EN
  input  logic                             force_en,
  input  logic [idx_width(NUM_CH)-1:0]     force_sel,
`endif
  input  logic [NUM_CH-1:0]                req,
  input  logic                             accept,
  output logic [NUM_CH-1:0]                gnt,
  output logic [idx_width(NUM_CH)-1:0]     gnt_idx,
  output logic                             gnt_any
);

  localparam int CH_W = idx_width(NUM_CH);
  // Eligibility is padded to a power of two so any CH_W-bit index is in range;
  // the padding bits are always zero, so indices >= NUM_CH are never granted.
  localparam int PAD = 1 << CH_W;
  localparam logic [CH_W:0] NUM_V = (CH_W+1)'(NUM_CH);

  logic [CH_W-1:0] ptr_r;
  logic [PAD-1:0]  elig_s;
  logic [PAD-1:0]  mask_s;
  logic [PAD-1:0]  gnt_pad_s;
  logic [CH_W:0]   cand_s;
  logic [CH_W-1:0] idx_s;
  logic            found_s;
  logic [CH_W:0]   nxt_wide_s;
  logic [CH_W-1:0] ptr_nxt_s;
  logic            adv_s;

  // Eligible channels: requesters, optionally narrowed to the forced channel.
  always_comb begin
    mask_s = '1;
`ifdef RR_MUX_FORCE_SEL_EN
    mask_s = force_en ? (PAD'(1'b1) << force_sel) : '1;
`endif
    elig_s = PAD'(req) & mask_s;
  end

  // Rotating priority search starting at ptr_r, wrapping modulo NUM_CH.
  always_comb begin
    cand_s  = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s = {1'b0, ptr_r} + (CH_W+1)'(k);
      cand_s = (cand_s >= NUM_V) ? (cand_s - NUM_V) : cand_s;
      if (!found_s && elig_s[cand_s[CH_W-1:0]]) begin
        found_s = 1'b1;
        idx_s   = cand_s[CH_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    gnt_pad_s = found_s ? (PAD'(1'b1) << idx_s) : '0;
  end

  // Next pointer: one past the winner, wrapping at NUM_CH-1 back to 0.
  always_comb begin
    nxt_wide_s = {1'b0, idx_s} + {{CH_W{1'b0}}, 1'b1};
    nxt_wide_s = (nxt_wide_s >= NUM_V) ? '0 : nxt_wide_s;
    ptr_nxt_s  = nxt_wide_s[CH_W-1:0];
    adv_s      = accept & found_s;
`ifdef RR_MUX_FORCE_SEL_EN
    // Forced transfers leave the round-robin order untouched.
    adv_s      = accept & found_s & ~force_en;
`endif
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (adv_s) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign gnt     = gnt_pad_s[NUM_CH-1:0];
  assign gnt_idx = idx_s;
  assign gnt_any = found_s;

endmodule : rr_arbiter

// File: rtl/rr_mux.sv
// -----------------------------------------------------------------------------
// rr_mux
// NUM_CH-input, WIDTH-bit multiplexer with valid/ready handshakes, round-robin
// arbitration and a single output register stage (1-cycle accept latency,
// full throughput when the output drains and refills in the same cycle).
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   force_en, force_sel : (RR_MUX_FORCE_SEL_EN only) legacy direct select
//   in_data             : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid, in_ready  : per-channel handshake (in_ready one-hot or zero)
//   out_data, out_ch    : registered beat and the channel it came from
//   out_valid, out_ready: output handshake
// Optional feature macro: RR_MUX_FORCE_SEL_EN
// -----------------------------------------------------------------------------
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
`ifdef RR_MUX_FORCE_SEL_EN
  input  logic                          force_en,
  input  logic [idx_width(NUM_CH)-1:0]  force_sel,
`endif
  input  logic [NUM_CH*WIDTH-1:0]       in_data,
  input  logic [NUM_CH-1:0]             in_valid,
  output logic [NUM_CH-1:0]             in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [idx_width(NUM_CH)-1:0]  out_ch,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int CH_W = idx_width(NUM_CH);

  logic              load_s;
  logic [NUM_CH-1:0] gnt_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic              gnt_any_s;
  logic [WIDTH-1:0]  sel_data_s;

  // Output slot is free, or its beat leaves this cycle.
  assign load_s = ~out_valid | out_ready;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .req       (in_valid),
    .accept    (load_s),
    .gnt       (gnt_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_any   (gnt_any_s)
  );

  // Ready is held low during reset even though the output slot reads as free.
  assign in_ready = gnt_s & {NUM_CH{load_s & reset_n}};

  // Data select driven by the one-hot grant.
  always_comb begin
    sel_data_s = {WIDTH{DATA_RST_BIT}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_s[i]) begin
        sel_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Output register: fill on grant, go empty on drain with no requester, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= {WIDTH{DATA_RST_BIT}};
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (load_s) begin
      if (gnt_any_s) begin
        out_data  <= sel_data_s;
        out_ch    <= gnt_idx_s;
        out_valid <= 1'b1;
      end else begin
        out_data  <= out_data;
        out_ch    <= out_ch;
        out_valid <= 1'b0;
      end
    end else begin
      out_data  <= out_data;
      out_ch    <= out_ch;
      out_valid <= out_valid;
    end
  end

endmodule : rr_mux

// File: tb/tb_rr_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_mux
// Directed bench for rr_mux: a 4-channel instance and a 3-channel instance
// (non-power-of-two wrap), both WIDTH=8. Define RR_MUX_FORCE_SEL_EN to also
// exercise the forced-select ports.
// -----------------------------------------------------------------------------
module tb_rr_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;

  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in3_data;
  logic [2:0]  in3_valid;
  logic [2:0]  in3_ready;
  logic [7:0]  out3_data;
  logic [1:0]  out3_ch;
  logic        out3_valid;
  logic        out3_ready;

  logic        f4_en;
  logic [1:0]  f4_sel;
  logic        f3_en;
  logic [1:0]  f3_sel;

  int checks = 0;
  int errors = 0;

  rr_mux #(.WIDTH(8), .NUM_CH(4)) dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en  (f4_en),
    .force_sel (f4_sel),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  rr_mux #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en  (f3_en),
    .force_sel (f3_sel),
`endif
    .in_data   (in3_data),
    .in_valid  (in3_valid),
    .in_ready  (in3_ready),
    .out_data  (out3_data),
    .out_ch    (out3_ch),
    .out_valid (out3_valid),
    .out_ready (out3_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_data    = 32'h0;
    in_valid   = 4'hF;
    out_ready  = 1'b1;
    in3_data   = 24'h0;
    in3_valid  = 3'b111;
    out3_ready = 1'b1;
    f4_en      = 1'b0;
    f4_sel     = 2'd0;
    f3_en      = 1'b0;
    f3_sel     = 2'd0;

    // Reset state, requests pending but ready must stay low
    #2;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_ch",    32'(out_ch),    32'h0);
    chk("rst_ready", 32'(in_ready),  32'h0);
    chk("rst_ready3", 32'(in3_ready), 32'h0);
    in_valid  = 4'h0;
    in3_valid = 3'b000;
    tick;
    tick;
    reset_n = 1'b1;
    settle;

    // Single channel: ch2 carries -54 (0xCA)
    in_data  = {8'h00, 8'hCA, 8'h00, 8'h00};
    in_valid = 4'b0100;
    settle;
    chk("single_ready", 32'(in_ready), 32'h4);
    tick;
    in_valid = 4'b0000;
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data",  32'(out_data),  32'hCA);
    chk("single_ch",    32'(out_ch),    32'h2);
    tick;
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_data_hold", 32'(out_data), 32'hCA);
    chk("idle_ch_hold",   32'(out_ch),   32'h2);

    // ptr=3, only ch1 valid -> ch1 wins, ptr becomes 2
    in_valid = 4'b0010;
    settle;
    chk("skip_ready", 32'(in_ready), 32'h2);
    tick;
    in_valid = 4'b0000;
    chk("skip_ch",    32'(out_ch),    32'h1);
    chk("skip_valid", 32'(out_valid), 32'h1);

    // ptr=2, only ch3 valid -> ch3 wins, ptr wraps to 0
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    in_valid = 4'b1000;
    settle;
    chk("wrap_ready", 32'(in_ready), 32'h8);
    tick;
    chk("wrap_ch",   32'(out_ch),   32'h3);
    chk("wrap_data", 32'(out_data), 32'h13);

    // Fairness: all valid, out_ready=1 -> 0,1,2,3,0,1 back to back
    in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("fair_ch",    32'(out_ch),    32'(i % 4));
      chk("fair_valid", 32'(out_valid), 32'h1);
      chk("fair_data",  32'(out_data),  32'h10 + 32'(i % 4));
    end

    // Backpressure: ptr=2, ch0=23 and ch1 valid -> ch0 first
    in_data  = {8'h13, 8'h12, 8'h55, 8'h17};
    in_valid = 4'b0011;
    settle;
    chk("bp_ready0", 32'(in_ready), 32'h1);
    tick;
    chk("bp_data0", 32'(out_data), 32'h17);
    chk("bp_ch0",   32'(out_ch),   32'h0);
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    settle;
    chk("bp_stall_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_hold_data",  32'(out_data),  32'h17);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_hold_ready", 32'(in_ready),  32'h0);
    end
    out_ready = 1'b1;
    settle;
    chk("bp_release_ready", 32'(in_ready), 32'h2);
    tick;
    chk("bp_data1", 32'(out_data), 32'h55);
    chk("bp_ch1",   32'(out_ch),   32'h1);
    // ptr should now be 2
    in_valid = 4'hF;
    settle;
    chk("bp_ptr2_ready", 32'(in_ready), 32'h4);
    tick;
    chk("bp_ch2", 32'(out_ch), 32'h2);

    // Reset in the middle of a stall drops the beat immediately
    out_ready = 1'b0;
    tick;
    chk("stall_valid", 32'(out_valid), 32'h1);
    chk("stall_ch",    32'(out_ch),    32'h2);
    reset_n = 1'b0;
    settle;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data",  32'(out_data),  32'h0);
    chk("midrst_ch",    32'(out_ch),    32'h0);
    chk("midrst_ready", 32'(in_ready),  32'h0);
    in_valid = 4'h0;
    tick;
    reset_n   = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    settle;
    chk("postrst_ready", 32'(in_ready), 32'h1);
    in_valid = 4'h0;

    // NUM_CH=3: ch2 wins, ptr wraps to 0
    in3_data  = {8'h33, 8'h22, 8'h11};
    in3_valid = 3'b100;
    settle;
    chk("n3_ready2", 32'(in3_ready), 32'h4);
    tick;
    chk("n3_ch2",    32'(out3_ch),    32'h2);
    chk("n3_data2",  32'(out3_data),  32'h33);
    chk("n3_valid2", 32'(out3_valid), 32'h1);
    in3_valid = 3'b111;
    settle;
    chk("n3_wrap_ready", 32'(in3_ready), 32'h1);
    tick;
    chk("n3_ch0",   32'(out3_ch),   32'h0);
    chk("n3_data0", 32'(out3_data), 32'h11);
    tick;
    chk("n3_ch1",   32'(out3_ch),   32'h1);
    chk("n3_data1", 32'(out3_data), 32'h22);
    in3_valid = 3'b000;
    tick;
    chk("n3_idle_valid", 32'(out3_valid), 32'h0);

`ifdef RR_MUX_FORCE_SEL_EN
    // Forced select of ch1 with all valid; pointer (0) must not move
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    f4_en    = 1'b1;
    f4_sel   = 2'd1;
    in_valid = 4'hF;
    settle;
    chk("force_ready", 32'(in_ready), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("force_ch",    32'(out_ch),   32'h1);
      chk("force_data",  32'(out_data), 32'h11);
      chk("force_ready_hold", 32'(in_ready), 32'h2);
    end
    f4_en = 1'b0;
    settle;
    chk("force_ptr_kept", 32'(in_ready), 32'h1);
    in_valid = 4'h0;

    // Forced select beyond NUM_CH-1 grants nothing
    f3_en     = 1'b1;
    f3_sel    = 2'd3;
    in3_valid = 3'b111;
    settle;
    chk("force_oob_ready", 32'(in3_ready), 32'h0);
    tick;
    chk("force_oob_valid", 32'(out3_valid), 32'h0);
    f3_en     = 1'b0;
    in3_valid = 3'b000;
`endif

    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rr_mux

// File: doc/rr_mux.md
Name: rr_mux

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes and round-robin arbitration. It replaces the fixed 2:1 combinational select mux wherever several producers share one datapath into the processor, such as writeback sources or operand forwarding. It has one output register stage, so the downstream sees a registered data/valid pair plus the index of the winning channel.

Parameters:
WIDTH, 8, data width per channel in bits (two's-complement data passes through unmodified)
NUM_CH, 4, number of input channels (>=2)
CH_W, $clog2(NUM_CH), width of channel index (derived, not overridable)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
in_data  input  NUM_CH*WIDTH  packed channel data, channel i at [i*WIDTH +: WIDTH]
in_valid  input  NUM_CH  channel i offers data
in_ready  output  NUM_CH  channel i data accepted this cycle (one-hot or zero)
out_data  output  WIDTH  registered selected data
out_ch  output  CH_W  index of channel that supplied out_data
out_valid  output  1  out_data/out_ch hold a valid beat
out_ready  input  1  downstream accepts beat when out_valid=1

Behaviour:
- Reset (async assert, sync deassert by clk): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0; in_ready=0 while reset_n=0.
- load = !out_valid | out_ready (output slot free or being drained this cycle).
- Grant: combinational; first i in order ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1 with in_valid[i]=1. gnt one-hot or zero.
- in_ready = gnt & {NUM_CH{load}}; in_ready must not depend on in_valid of other channels except via arbitration.
- Transfer when in_valid[i] & in_ready[i]: next edge out_data<=chan i data, out_ch<=i, out_valid<=1, ptr<=(i+1) mod NUM_CH (wrap at NUM_CH-1 -> 0).
- load=1 with no valid input: out_valid<=0, out_data/out_ch hold, ptr holds.
- Stall (out_valid=1, out_ready=0): out_* hold stable, in_ready=0, ptr holds.
- Simultaneous drain and fill: full throughput, one beat per cycle, no bubble.
- Latency: input accept to out_valid = 1 cycle.
- Non-power-of-2 NUM_CH: indices >= NUM_CH never granted; pointer wrap is mod NUM_CH.
- Reset mid-stall: in-flight beat dropped; out_valid=0 immediately (async).
- Producers must hold in_data/in_valid until accepted; rr_mux does not check this.

Optional Feature:
RR_MUX_FORCE_SEL_EN. When defined, adds ports force_en (input, 1) and force_sel (input, CH_W). When force_en=1, only channel force_sel is eligible for grant; other channels see in_ready=0. ptr is not updated on forced transfers. force_sel >= NUM_CH means no grant. This gives the legacy direct-select mux behaviour, registered. When not defined, these ports are absent and arbitration is pure round-robin.

Decomposition:
- Package rr_mux_pkg: function for index width (clog2, min 1) and reset constant for data (all zeros).
- Sub-module rr_arbiter: holds ptr register, rotate/priority-encode grant, one-hot gnt and encoded index out, ptr update on accept. Same clk/reset_n.
- rr_mux top: output register, load logic, data select from gnt index.

Test Plan:
- Reset: reset_n=0 mid-operation with out_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 asynchronously.
- Single channel, WIDTH=8, NUM_CH=4, out_ready=1: ch2 data=-54 valid one cycle -> next cycle out_valid=1, out_data=8'hCA, out_ch=2.
- Fairness: all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with no bubbles.
- Backpressure: out_ready=0 for 3 cycles with ch0=23 and ch1 valid -> out_data holds 23, in_ready=0; release -> ch1 granted next, ptr=2.
- Wrap and skip: ptr=3, only ch1 valid -> ch1 granted, ptr becomes 2; NUM_CH=3 build with ch2 last -> ptr wraps to 0.
- RR_MUX_FORCE_SEL_EN: force_en=1, force_sel=1, all valid -> only ch1 accepted every cycle, ptr unchanged; force_sel=3 with NUM_CH=3 -> no grant.
